// File: rtl/hex_entry_pkg.sv
// Shared constants and event encoding for the hex entry buffer.
// Latency: n/a; backpressure: n/a.
package hex_entry_pkg;
   localparam int NUM_NIBBLES      = 16;
   localparam int COUNT_W          = 5;
   localparam int WORD_W           = 64;
   localparam int DEFAULT_DEBOUNCE = 500000;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_CLEAR,
      EV_BACK,
      EV_LOAD
   } event_e;
endpackage

// File: rtl/button_debouncer.sv
// Synchronizes, debounces and edge-detects one active-low push button.
// Latency: 2 sync + DEBOUNCE_CYCLES to level/press; backpressure: none, press is a one-cycle pulse.
module button_debouncer
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
   input  logic iCLK,
   input  logic iRST_N,
   input  logic iBTN_N,
   output logic oLEVEL,
   output logic oPRESS
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic [1:0]       flush_q, flush_d;
   logic             armed_q, armed_d;

   always_comb begin
      sync1_d = iBTN_N;
      sync2_d = sync1_q;
      flush_d = {flush_q[0], 1'b1};
      // Presses are only honoured once the button has been seen released after reset,
      // so a button held through reset release never yields an event on its first settle.
      armed_d = armed_q | (flush_q[1] & sync2_q);
      level_d = level_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = ~level_q;
         cnt_d   = '0;
         press_d = level_q & armed_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
         flush_q <= 2'b00;
         armed_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         flush_q <= flush_d;
         armed_q <= armed_d;
      end
   end

   assign oLEVEL = level_q;
   assign oPRESS = press_q;
endmodule

// File: rtl/hex_entry_buffer.sv
// Builds a 16-nibble word from switch digits under load/backspace/clear buttons.
// Latency: outputs update one cycle after a press event; backpressure: none, extra events dropped.
module hex_entry_buffer
   import hex_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [3:0]        iNIB,
   input  logic              iLOAD_N,
   input  logic              iBACK_N,
   input  logic              iCLEAR_N,
   output logic [WORD_W-1:0] oVALUES,
   output logic [COUNT_W-1:0] oCOUNT,
   output logic              oFULL,
   output logic              oUPDATE
);
   logic [3:0]         nib_s1_q, nib_s1_d;
   logic [3:0]         nib_s2_q, nib_s2_d;
   logic [WORD_W-1:0]  values_q, values_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               full_q, full_d;
   logic               update_q, update_d;
   logic               load_press, back_press, clear_press;
   logic               load_level, back_level, clear_level;
   event_e             ev;

   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
      .iCLK(iCLK), .iRST_N(iRST_N), .iBTN_N(iLOAD_N), .oLEVEL(load_level), .oPRESS(load_press)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
      .iCLK(iCLK), .iRST_N(iRST_N), .iBTN_N(iBACK_N), .oLEVEL(back_level), .oPRESS(back_press)
   );
   button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .iCLK(iCLK), .iRST_N(iRST_N), .iBTN_N(iCLEAR_N), .oLEVEL(clear_level), .oPRESS(clear_press)
   );

   always_comb begin
      if (clear_press)      ev = EV_CLEAR;
      else if (back_press)  ev = EV_BACK;
      else if (load_press)  ev = EV_LOAD;
      else                  ev = EV_NONE;
   end

   always_comb begin
      nib_s1_d = iNIB;
      nib_s2_d = nib_s1_q;
      values_d = values_q;
      count_d  = count_q;
      update_d = 1'b0;
      unique case (ev)
         EV_CLEAR: begin
            values_d = '0;
            count_d  = '0;
            update_d = 1'b1;
         end
         EV_BACK: begin
            if (count_q != '0) begin
               for (int k = 0; k < NUM_NIBBLES; k++) begin
                  if (COUNT_W'(k + 1) == count_q) values_d[WORD_W-1-4*k -: 4] = 4'h0;
               end
               count_d  = count_q - COUNT_W'(1);
               update_d = 1'b1;
            end
         end
         EV_LOAD: begin
            if (count_q != COUNT_W'(NUM_NIBBLES)) begin
               for (int k = 0; k < NUM_NIBBLES; k++) begin
                  if (COUNT_W'(k) == count_q) values_d[WORD_W-1-4*k -: 4] = nib_s2_q;
               end
               count_d  = count_q + COUNT_W'(1);
               update_d = 1'b1;
            end
         end
         default: ;
      endcase
      full_d = (count_d == COUNT_W'(NUM_NIBBLES));
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         nib_s1_q <= '0;
         nib_s2_q <= '0;
         values_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         update_q <= 1'b0;
      end else begin
         nib_s1_q <= nib_s1_d;
         nib_s2_q <= nib_s2_d;
         values_q <= values_d;
         count_q  <= count_d;
         full_q   <= full_d;
         update_q <= update_d;
      end
   end

   assign oVALUES = values_q;
   assign oCOUNT  = count_q;
   assign oFULL   = full_q;
   assign oUPDATE = update_q;
endmodule

// File: tb/tb_hex_entry_buffer.sv
// Self-checking bench for hex_entry_buffer with a short debounce window.
// Expected word/count snapshots queue up as presses are driven and are matched against each oUPDATE pulse.
module tb_hex_entry_buffer;
   localparam int DEB = 4;

   logic        iCLK = 1'b0;
   logic        iRST_N;
   logic [3:0]  iNIB;
   logic        iLOAD_N, iBACK_N, iCLEAR_N;
   logic [63:0] oVALUES;
   logic [4:0]  oCOUNT;
   logic        oFULL, oUPDATE;

   always #5 iCLK = ~iCLK;

   hex_entry_buffer #(.DEBOUNCE_CYCLES(DEB)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iNIB(iNIB), .iLOAD_N(iLOAD_N), .iBACK_N(iBACK_N),
      .iCLEAR_N(iCLEAR_N), .oVALUES(oVALUES), .oCOUNT(oCOUNT), .oFULL(oFULL), .oUPDATE(oUPDATE)
   );

   typedef struct packed {
      logic [63:0] v;
      logic [4:0]  c;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   int          upd_seen = 0;
   logic [63:0] m_vals = '0;
   logic [4:0]  m_cnt = '0;

   always @(negedge iCLK) begin
      if (oUPDATE === 1'b1) begin
         upd_seen++;
         n_vec++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_update: got values=%h count=%0d, expected no update", oVALUES, oCOUNT);
         end else begin
            mon_e = sb_q.pop_front();
            if (oVALUES !== mon_e.v || oCOUNT !== mon_e.c || oFULL !== (mon_e.c == 5'd16)) begin
               n_err++;
               $display("FAIL update_value: got values=%h count=%0d full=%b, expected values=%h count=%0d full=%b",
                        oVALUES, oCOUNT, oFULL, mon_e.v, mon_e.c, (mon_e.c == 5'd16));
            end
         end
      end
   end

   task automatic set_btn(input int which, input logic v);
      case (which)
         0:       iLOAD_N  = v;
         1:       iBACK_N  = v;
         default: iCLEAR_N = v;
      endcase
   endtask

   task automatic model_event(input int which, input logic [3:0] nib);
      exp_t e;
      int   idx;
      idx = int'(m_cnt);
      case (which)
         0: if (m_cnt < 5'd16) begin
               m_vals[63-4*idx -: 4] = nib;
               m_cnt = m_cnt + 5'd1;
               e.v = m_vals; e.c = m_cnt; sb_q.push_back(e);
            end
         1: if (m_cnt > 5'd0) begin
               m_vals[63-4*(idx-1) -: 4] = 4'h0;
               m_cnt = m_cnt - 5'd1;
               e.v = m_vals; e.c = m_cnt; sb_q.push_back(e);
            end
         default: begin
               m_vals = '0;
               m_cnt  = '0;
               e.v = m_vals; e.c = m_cnt; sb_q.push_back(e);
            end
      endcase
   endtask

   // Clean press: held 10 cycles, released 12 cycles; lat = cycles from press to oUPDATE (-1 if none).
   task automatic press(input int which, input logic [3:0] nib, output int lat);
      lat  = -1;
      iNIB = nib;
      @(posedge iCLK); #1;
      model_event(which, nib);
      set_btn(which, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         @(posedge iCLK); #1;
         if (lat < 0 && oUPDATE === 1'b1) lat = i;
      end
      set_btn(which, 1'b1);
      repeat (12) @(posedge iCLK);
      #1;
   endtask

   task automatic test_reset();
      iRST_N = 1'b0; iNIB = 4'h0; iLOAD_N = 1'b1; iBACK_N = 1'b1; iCLEAR_N = 1'b1;
      repeat (3) @(posedge iCLK);
      #1;
      n_vec++;
      if (oVALUES !== 64'h0 || oCOUNT !== 5'd0 || oFULL !== 1'b0 || oUPDATE !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state: got values=%h count=%0d full=%b upd=%b, expected all 0", oVALUES, oCOUNT, oFULL, oUPDATE);
      end
      iRST_N = 1'b1;
      repeat (10) @(posedge iCLK);
      #1;
      n_vec++;
      if (upd_seen !== 0 || oCOUNT !== 5'd0) begin
         n_err++;
         $display("FAIL post_reset_quiet: got updates=%0d count=%0d, expected 0 and 0", upd_seen, oCOUNT);
      end
   endtask

   task automatic test_load_basic();
      logic [3:0] d [4];
      int lat, u0;
      d = '{4'h1, 4'h3, 4'h3, 4'h4};
      for (int i = 0; i < 4; i++) begin
         u0 = upd_seen;
         press(0, d[i], lat);
         n_vec++;
         if (lat < DEB + 2 || lat > DEB + 4 || upd_seen != u0 + 1) begin
            n_err++;
            $display("FAIL load_latency[%0d]: got lat=%0d pulses=%0d, expected lat %0d..%0d and 1 pulse",
                     i, lat, upd_seen - u0, DEB + 2, DEB + 4);
         end
      end
      n_vec++;
      if (oVALUES !== 64'h1334_0000_0000_0000 || oCOUNT !== 5'd4 || oFULL !== 1'b0) begin
         n_err++;
         $display("FAIL load_four: got values=%h count=%0d full=%b, expected 1334000000000000 4 0", oVALUES, oCOUNT, oFULL);
      end
   endtask

   task automatic test_full();
      logic [3:0] d [16];
      int lat, u0;
      d = '{4'h1, 4'h3, 4'h3, 4'h4, 4'h5, 4'h7, 4'h7, 4'h9, 4'h9, 4'hB, 4'hB, 4'hC, 4'hD, 4'hF, 4'hF, 4'h1};
      for (int i = 4; i < 16; i++) press(0, d[i], lat);
      n_vec++;
      if (oVALUES !== 64'h133457799BBCDFF1 || oCOUNT !== 5'd16 || oFULL !== 1'b1) begin
         n_err++;
         $display("FAIL fill16: got values=%h count=%0d full=%b, expected 133457799bbcdff1 16 1", oVALUES, oCOUNT, oFULL);
      end
      u0 = upd_seen;
      press(0, 4'h0, lat);
      n_vec++;
      if (upd_seen != u0 || oVALUES !== 64'h133457799BBCDFF1 || oCOUNT !== 5'd16) begin
         n_err++;
         $display("FAIL load_when_full: got pulses=%0d values=%h count=%0d, expected 0 pulses, unchanged", upd_seen - u0, oVALUES, oCOUNT);
      end
   endtask

   task automatic test_backspace();
      int lat, u0;
      press(1, 4'h0, lat);
      press(1, 4'h0, lat);
      n_vec++;
      if (oVALUES !== 64'h133457799BBCDF00 || oCOUNT !== 5'd14 || oFULL !== 1'b0) begin
         n_err++;
         $display("FAIL back2: got values=%h count=%0d full=%b, expected 133457799bbcdf00 14 0", oVALUES, oCOUNT, oFULL);
      end
      for (int i = 0; i < 14; i++) press(1, 4'h0, lat);
      n_vec++;
      if (oVALUES !== 64'h0 || oCOUNT !== 5'd0) begin
         n_err++;
         $display("FAIL back_to_empty: got values=%h count=%0d, expected 0 0", oVALUES, oCOUNT);
      end
      u0 = upd_seen;
      press(1, 4'h0, lat);
      n_vec++;
      if (upd_seen != u0 || oCOUNT !== 5'd0) begin
         n_err++;
         $display("FAIL back_when_empty: got pulses=%0d count=%0d, expected 0 pulses count 0", upd_seen - u0, oCOUNT);
      end
   endtask

   task automatic test_glitch();
      int u0;
      iNIB = 4'h6;
      u0 = upd_seen;
      for (int g = 1; g <= 3; g++) begin
         @(posedge iCLK); #1;
         iLOAD_N = 1'b0;
         repeat (g) @(posedge iCLK);
         #1;
         iLOAD_N = 1'b1;
         repeat (3) @(posedge iCLK);
      end
      repeat (8) @(posedge iCLK);
      #1;
      n_vec++;
      if (upd_seen != u0 || oCOUNT !== 5'd0) begin
         n_err++;
         $display("FAIL glitch_rejected: got pulses=%0d count=%0d, expected 0 pulses count 0", upd_seen - u0, oCOUNT);
      end
      model_event(0, 4'h6);
      iLOAD_N = 1'b0;
      repeat (20) @(posedge iCLK);
      #1;
      iLOAD_N = 1'b1;
      repeat (12) @(posedge iCLK);
      #1;
      n_vec++;
      if (upd_seen != u0 + 1 || oVALUES !== 64'h6000_0000_0000_0000 || oCOUNT !== 5'd1) begin
         n_err++;
         $display("FAIL long_hold_once: got pulses=%0d values=%h count=%0d, expected 1 pulse 6000000000000000 1",
                  upd_seen - u0, oVALUES, oCOUNT);
      end
   endtask

   task automatic test_simultaneous();
      int lat, u0;
      for (int i = 2; i <= 5; i++) press(0, 4'(i), lat);
      n_vec++;
      if (oCOUNT !== 5'd5 || oVALUES !== 64'h6234_5000_0000_0000) begin
         n_err++;
         $display("FAIL pre_simul: got values=%h count=%0d, expected 6234500000000000 5", oVALUES, oCOUNT);
      end
      u0 = upd_seen;
      iNIB = 4'h9;
      @(posedge iCLK); #1;
      model_event(2, 4'h0);
      iLOAD_N = 1'b0; iCLEAR_N = 1'b0;
      repeat (10) @(posedge iCLK);
      #1;
      iLOAD_N = 1'b1; iCLEAR_N = 1'b1;
      repeat (12) @(posedge iCLK);
      #1;
      n_vec++;
      if (upd_seen != u0 + 1 || oVALUES !== 64'h0 || oCOUNT !== 5'd0) begin
         n_err++;
         $display("FAIL clear_beats_load: got pulses=%0d values=%h count=%0d, expected 1 pulse 0 0", upd_seen - u0, oVALUES, oCOUNT);
      end
   endtask

   task automatic test_reset_mid_press();
      int lat, u0;
      for (int i = 7; i <= 9; i++) press(0, 4'(i), lat);
      iNIB = 4'hA;
      @(posedge iCLK); #1;
      iLOAD_N = 1'b0;
      repeat (3) @(posedge iCLK);
      #1;
      iRST_N = 1'b0;
      #1;
      n_vec++;
      if (oVALUES !== 64'h0 || oCOUNT !== 5'd0 || oFULL !== 1'b0 || oUPDATE !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got values=%h count=%0d full=%b upd=%b, expected all 0", oVALUES, oCOUNT, oFULL, oUPDATE);
      end
      m_vals = '0; m_cnt = '0;
      sb_q.delete();
      repeat (2) @(posedge iCLK);
      #1;
      iRST_N = 1'b1;
      u0 = upd_seen;
      repeat (20) @(posedge iCLK);
      #1;
      n_vec++;
      if (upd_seen != u0 || oCOUNT !== 5'd0) begin
         n_err++;
         $display("FAIL held_through_reset: got pulses=%0d count=%0d, expected 0 pulses count 0", upd_seen - u0, oCOUNT);
      end
      iLOAD_N = 1'b1;
      repeat (12) @(posedge iCLK);
      #1;
      n_vec++;
      if (upd_seen != u0) begin
         n_err++;
         $display("FAIL release_after_reset: got pulses=%0d, expected 0", upd_seen - u0);
      end
      press(0, 4'hA, lat);
      n_vec++;
      if (upd_seen != u0 + 1 || oVALUES !== 64'hA000_0000_0000_0000 || oCOUNT !== 5'd1) begin
         n_err++;
         $display("FAIL repress_after_reset: got pulses=%0d values=%h count=%0d, expected 1 pulse a000000000000000 1",
                  upd_seen - u0, oVALUES, oCOUNT);
      end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_full();
      test_backspace();
      test_glitch();
      test_simultaneous();
      test_reset_mid_press();
      n_vec++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending expected updates, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
